// File: rtl/adder_pkg.sv
// adder_pkg: KGP encoding constants and pipeline depth helpers shared by the prefix adder
package adder_pkg;
  localparam logic [1:0] KGP_K = 2'b00;
  localparam logic [1:0] KGP_P = 2'b01;
  localparam logic [1:0] KGP_G = 2'b11;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int lat_of(input int w, input int lps);
    return (clog2(w) + lps - 1) / lps + 1;
  endfunction
endpackage

// File: rtl/kgp_cell.sv
// kgp_cell: prefix operator combining a high group with the adjacent low group
module kgp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: pipelined Kogge-Stone adder/subtractor with valid/ready flow control
module pipelined_prefix_adder
  import adder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LVL_PER_STG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int LOG2W = clog2(WIDTH);
  localparam int NSTG  = lat_of(WIDTH, LVL_PER_STG) - 1;
  logic en, c_e, unused_p;
  logic [WIDTH-1:0] b_e, c, s_n;
  logic [LOG2W:0][WIDTH-1:0] gl, pl;
  logic [LOG2W-1:0][WIDTH-1:0] go, po;
  logic [NSTG-1:0][WIDTH-1:0] a_r, be_r, g_r, p_r;
  logic [NSTG-1:0] v_r, ce_r;
  genvar i, l, j, s;
  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  assign b_e = b ^ {WIDTH{sub}};
  assign c_e = cin ^ sub;
  assign {gl[0][0], pl[0][0]} = (a[0] & b_e[0] | a[0] & c_e | b_e[0] & c_e) ? KGP_G : KGP_K;
  for (i = 1; i < WIDTH; i++) begin : kgp0
    assign {gl[0][i], pl[0][i]} = (a[i] & b_e[i]) ? KGP_G : (a[i] | b_e[i]) ? KGP_P : KGP_K;
  end
  for (l = 0; l < LOG2W; l++) begin : lvl
    for (j = 0; j < WIDTH; j++) begin : col
      if (j >= 2 ** l) begin : op
        kgp_cell u_cell (
          .g_hi(gl[l][j]),
          .p_hi(pl[l][j]),
          .g_lo(gl[l][j-2**l]),
          .p_lo(pl[l][j-2**l]),
          .g   (go[l][j]),
          .p   (po[l][j])
        );
      end else begin : pass
        assign {go[l][j], po[l][j]} = {gl[l][j], pl[l][j]};
      end
    end
    if ((l + 1) % LVL_PER_STG == 0 || l == LOG2W - 1) begin : reg_in
      assign {gl[l+1], pl[l+1]} = {g_r[l/LVL_PER_STG], p_r[l/LVL_PER_STG]};
    end else begin : comb_in
      assign {gl[l+1], pl[l+1]} = {go[l], po[l]};
    end
  end
  for (s = 0; s < NSTG; s++) begin : stg
    localparam int LS = ((s + 1) * LVL_PER_STG < LOG2W ? (s + 1) * LVL_PER_STG : LOG2W) - 1;
    logic v_i, ce_i;
    logic [WIDTH-1:0] a_i, be_i;
    if (s == 0) begin : head
      assign {v_i, a_i, be_i, ce_i} = {in_valid, a, b_e, c_e};
    end else begin : tail
      assign {v_i, a_i, be_i, ce_i} = {v_r[s-1], a_r[s-1], be_r[s-1], ce_r[s-1]};
    end
    always_ff @(posedge clk)
      if (rst) v_r[s] <= 1'b0;
      else if (en) {v_r[s], a_r[s], be_r[s], ce_r[s], g_r[s], p_r[s]} <= {v_i, a_i, be_i, ce_i, go[LS], po[LS]};
  end
  assign c = {gl[LOG2W][WIDTH-2:0], ce_r[NSTG-1]};
  assign s_n = a_r[NSTG-1] ^ be_r[NSTG-1] ^ c;
  assign unused_p = ^pl[LOG2W];
  always_ff @(posedge clk)
    if (rst) {out_valid, sum, cout, ovf, zero} <= '0;
    else if (en) begin
      out_valid <= v_r[NSTG-1];
      if (v_r[NSTG-1]) {sum, cout, ovf, zero} <= {s_n, gl[LOG2W][WIDTH-1], c[WIDTH-1] ^ gl[LOG2W][WIDTH-1], ~|s_n};
    end
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: random and directed checks of both pipeline depths against an arithmetic model
module tb_pipelined_prefix_adder;
  logic clk, rst;
  logic [1:0] in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [31:0] sum [2];
  logic [34:0] exp_q [2][$];
  localparam int LATV [2] = '{6, 2};
  int checks, failures, ncyc;
  int ins [2];
  int outs [2];
  for (genvar k = 0; k < 2; k++) begin : g_dut
    pipelined_prefix_adder #(.WIDTH(32), .LVL_PER_STG(k == 0 ? 1 : 5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid[k]), .in_ready(in_ready[k]),
      .a(a[k]), .b(b[k]), .cin(cin[k]), .sub(sub[k]),
      .out_valid(out_valid[k]), .out_ready(out_ready[k]),
      .sum(sum[k]), .cout(cout[k]), .ovf(ovf[k]), .zero(zero[k])
    );
  end
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
    longint ua, ub, sa, sb_, c, r, sr;
    logic [31:0] s;
    logic co, ov;
    ua = x; ub = y; sa = $signed(x); sb_ = $signed(y); c = ci;
    if (!sb) begin
      r = ua + ub + c; sr = sa + sb_ + c; co = r >= 64'sh1_0000_0000;
    end else begin
      r = ua - ub - c; sr = sa - sb_ - c; co = r >= 0;
    end
    s = r[31:0];
    ov = sr > 64'sh7FFF_FFFF || sr < -64'sh8000_0000;
    return {s, co, ov, s == 0};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    ncyc++;
    for (int kk = 0; kk < 2; kk++) if (!rst) begin
      if (out_valid[kk] && out_ready[kk]) begin
        outs[kk]++;
        chk("result_expected", 64'(exp_q[kk].size() != 0), 64'd1);
        if (exp_q[kk].size() != 0) chk("stream", {sum[kk], cout[kk], ovf[kk], zero[kk]}, exp_q[kk].pop_front());
      end
      if (in_valid[kk] && in_ready[kk]) begin
        ins[kk]++;
        exp_q[kk].push_back(model(a[kk], b[kk], cin[kk], sub[kk]));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int k, input logic v);
    in_valid[k] = v;
    a[k] = $urandom;
    b[k] = ($urandom % 8 == 0) ? a[k] : $urandom;
    cin[k] = 1'($urandom % 2);
    sub[k] = 1'($urandom % 2);
  endtask
  task automatic drain(input int k);
    int n;
    in_valid[k] = 0;
    out_ready[k] = 1;
    n = 0;
    while (exp_q[k].size() != 0 && n < 60) begin cyc(); n++; end
    chk("drain_empty", 64'(exp_q[k].size()), 64'd0);
  endtask
  task automatic directed(input int k, input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb,
                          input logic [31:0] es, input logic ec, input logic eo);
    int n;
    out_ready[k] = 1;
    in_valid[k] = 1; a[k] = x; b[k] = y; cin[k] = ci; sub[k] = sb;
    cyc();
    in_valid[k] = 0;
    n = 1;
    while (!out_valid[k] && n < 20) begin cyc(); n++; end
    chk("latency", 64'(n), 64'(LATV[k]));
    chk("directed", {sum[k], cout[k], ovf[k], zero[k]}, {es, ec, eo, es == 0});
    cyc();
  endtask
  initial begin
    int n, f, o0, i0;
    checks = 0; failures = 0; ncyc = 0;
    ins = '{0, 0}; outs = '{0, 0};
    rst = 1; in_valid = 0; out_ready = 0; cin = 0; sub = 0;
    a = '{0, 0}; b = '{0, 0};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 2; k++) begin
      chk("reset_out", {out_valid[k], sum[k], cout[k], ovf[k], zero[k]}, 64'd0);
      chk("reset_ready", 64'(in_ready[k]), 64'd1);
    end
    out_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      directed(k, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'h0, 1, 0);
      directed(k, 32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 0, 1);
      directed(k, 32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0);
      directed(k, 32'd9, 32'd4, 1, 1, 32'd4, 1, 0);
      directed(k, 32'h8000_0000, 32'd1, 0, 1, 32'h7FFF_FFFF, 1, 1);
      o0 = outs[k]; n = 0; f = -1;
      for (int i = 0; outs[k] < o0 + 100 && n < 300; i++) begin
        drive(k, i < 100);
        cyc(); n++;
        if (f < 0 && outs[k] > o0) f = n;
      end
      chk("thru_count", 64'(outs[k] - o0), 64'd100);
      chk("thru_span", 64'(n - f), 64'd99);
      drain(k);
      o0 = outs[k]; i0 = ins[k];
      repeat (20) begin drive(k, 1); cyc(); end
      out_ready[k] = 0;
      drive(k, 1);
      chk("stall_valid", 64'(out_valid[k]), 64'd1);
      f = {sum[k], cout[k], ovf[k], zero[k]} == 0 ? 0 : 1;
      begin
        logic [34:0] snap;
        snap = {sum[k], cout[k], ovf[k], zero[k]};
        repeat (10) begin
          cyc();
          chk("stall_ready", 64'(in_ready[k]), 64'd0);
          chk("stall_hold", {out_valid[k], sum[k], cout[k], ovf[k], zero[k]}, {1'b1, snap});
          drive(k, 1);
        end
      end
      out_ready[k] = 1;
      repeat (10) begin drive(k, 1); cyc(); end
      drain(k);
      chk("stall_conserve", 64'(outs[k] - o0), 64'(ins[k] - i0));
      o0 = outs[k]; i0 = ins[k];
      for (int i = 0; i < 200; i++) begin
        drive(k, i % 2 == 0);
        out_ready[k] = 1'($urandom % 2);
        cyc();
      end
      drain(k);
      chk("bubble_conserve", 64'(outs[k] - o0), 64'(ins[k] - i0));
      out_ready[k] = 1;
      repeat (LATV[k]) begin drive(k, 1); cyc(); end
      rst = 1; in_valid[k] = 0;
      exp_q[0].delete(); exp_q[1].delete();
      @(posedge clk);
      #1 rst = 0;
      out_ready[k] = 0;
      chk("midrst_out", {out_valid[k], sum[k], cout[k], ovf[k], zero[k]}, 64'd0);
      chk("midrst_ready", 64'(in_ready[k]), 64'd1);
      out_ready[k] = 1;
      o0 = outs[k];
      repeat (20) cyc();
      chk("no_stale", 64'(outs[k] - o0), 64'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
